qubo_demon_sched: RTL

QUBO_DEMON_SCHED -- requirements
Module: qubo_demon_sched

---
 rtl/qubo_demon_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/qubo_demon_sched.sv
// qubo_demon_sched
// Sequences a microcanonical (demon) annealing run over a spin vector.
// Each spin is offered in turn to an external datapath, which returns the
// signed energy change for flipping it. The flip is taken only when the demon
// can pay for it, and the demon absorbs whatever energy the flip releases.
// A run is MAX_COUNT full sweeps. After that the block parks in DONE.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   ena          global enable; low freezes every register
//   start        run request, honoured in IDLE and DONE only
//   demon_init   demon energy loaded at run start
//   de_req       asks the datapath for the energy change of spin de_idx
//   de_idx       spin under evaluation
//   de_valid     datapath response strobe, honoured in REQ only
//   de_val       signed energy change if spin de_idx flips
//   spins        current spin vector
//   demon_e      current demon energy
//   sweep_cnt    sweeps completed in this run
//   busy, done   run in progress / run finished
//
// state | meaning
// IDLE  | after reset, waiting for start
// REQ   | de_req high, waiting for the datapath response
// APPLY | one cycle: accept/reject the flip, advance the index
// DONE  | run finished, results held until start or reset
module qubo_demon_sched #(
  parameter int N_SPINS   = 8,
  parameter int E_WIDTH   = 8,
  parameter int MAX_COUNT = 10000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           start,
  input  logic [E_WIDTH-1:0]             demon_init,
  output logic                           de_req,
  output logic [$clog2(N_SPINS)-1:0]     de_idx,
  input  logic                           de_valid,
  input  logic [E_WIDTH:0]               de_val,
  output logic [N_SPINS-1:0]             spins,
  output logic [E_WIDTH-1:0]             demon_e,
  output logic [$clog2(MAX_COUNT+1)-1:0] sweep_cnt,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = $clog2(N_SPINS);
  localparam int CNT_W = $clog2(MAX_COUNT+1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SPINS-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_APPLY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [N_SPINS-1:0]   spins_q, spins_d;
  logic [E_WIDTH-1:0]   demon_q, demon_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [E_WIDTH:0]     val_q, val_d;
  logic                 accept;
  logic signed [E_WIDTH+1:0] diff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      spins_q <= '0;
      demon_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      spins_q <= spins_d;
      demon_q <= demon_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    spins_d = spins_q;
    demon_d = demon_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    accept  = 1'b0;
    diff    = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          demon_d = demon_init;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (de_valid) begin
          val_d   = de_val;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        // demon is zero-extended so it always compares as non-negative
        accept = $signed(val_q) <= $signed({1'b0, demon_q});
        // two guard bits: a negative de_val can push the sum past 2^E_WIDTH-1
        diff = $signed({2'b00, demon_q}) - $signed({val_q[E_WIDTH], val_q});
        if (accept) begin
          spins_d[idx_q] = ~spins_q[idx_q];
          demon_d = (|diff[E_WIDTH+1:E_WIDTH]) ? '1 : diff[E_WIDTH-1:0];
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_MAX) ? S_DONE : S_REQ;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign de_req    = (state_q == S_REQ);
  assign busy      = (state_q == S_REQ) || (state_q == S_APPLY);
  assign done      = (state_q == S_DONE);
  assign de_idx    = idx_q;
  assign spins     = spins_q;
  assign demon_e   = demon_q;
  assign sweep_cnt = cnt_q;

endmodule
